rv32i_branch_resolve: RTL and testbench
=======================================

RV32I_BRANCH_RESOLVE -- requirements
Module: rv32i_branch_resolve

Interface
REQ-001 Parameter: PHT_ENTRIES, default 16, number of 2-bit predictor entries (power of two, 4..256).
REQ-002 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 ex_valid  in  1  EX-stage instruction valid.
REQ-006 ex_is_branch / ex_is_jal / ex_is_jalr  in  1 each  control-transfer class; at most one set.
REQ-007 ex_pc  in  32  PC of EX instruction.
REQ-008 ex_imm  in  32  sign-extended immediate.
REQ-009 ex_rs1_data  in  32  rs1 operand, used for JALR.
REQ-010 branch_taken  in  1  condition result from the branch comparator.
REQ-011 ex_pred_taken  in  1  fetch-time prediction.
REQ-012 ex_pred_target  in  32  fetch-time predicted target.
REQ-013 ex_ready  out  1  resolution accepted this cycle.
REQ-014 redirect_valid  out  1  fetch redirect request.
REQ-015 redirect_pc  out  32  corrected fetch PC.
REQ-016 redirect_ready  in  1  fetch accepts redirect.
REQ-017 flush  out  1  one-cycle kill of younger IF/ID instructions.
REQ-018 misalign_err  out  1  one-cycle instruction-address-misaligned pulse.
REQ-019 if_pc  in  32  fetch PC for prediction lookup.
REQ-020 if_pred_taken  out  1  combinational prediction, equal to MSB of PHT[if_pc index].
REQ-021 mispredict_count  out  32  saturating mispredict counter.

Function
REQ-022 Resolution occurs on a cycle with ex_valid & ex_ready and any class bit set; all other cycles take no action.
REQ-023 actual_taken = branch_taken for a branch; 1 for JAL/JALR.
REQ-024 Target = ex_pc+ex_imm for branch/JAL; (ex_rs1_data+ex_imm) & ~1 for JALR; all additions are 32-bit wrap-around.
REQ-025 correct_pc = actual_taken ? target : ex_pc+4.
REQ-026 Mispredict = (ex_pred_taken != actual_taken) | (actual_taken & ex_pred_target != target).
REQ-027 Misalignment (actual_taken & target[1:0] != 0) has priority over mispredict: misalign_err = 1 next cycle, no redirect, no flush, and the counter is not incremented.
REQ-028 FSM states IDLE, REDIRECT; ex_ready = (state == IDLE).
REQ-029 IDLE -> REDIRECT on an aligned mispredict; redirect_pc is registered, and redirect_valid and flush are 1 on the following cycle.
REQ-030 flush is high only on the first REDIRECT cycle.
REQ-031 REDIRECT holds redirect_valid and a stable redirect_pc until redirect_valid & redirect_ready, then returns to IDLE on the next edge.
REQ-032 While in REDIRECT, ex_valid is ignored and no PHT update occurs.
REQ-033 mispredict_count increments by 1 per aligned mispredict and saturates at 0xFFFFFFFF.
REQ-034 PHT index = pc[$clog2(PHT_ENTRIES)+1:2].
REQ-035 The PHT is updated only on resolved conditional branches (including misaligned ones): increment if taken, decrement if not, saturating at 00 and 11; the write takes effect at the clock edge.
REQ-036 When if_pc and ex_pc index the same entry in the update cycle, if_pred_taken returns the pre-update value.

Reset
REQ-037 On rst: state = IDLE, redirect_valid = 0, redirect_pc = 0, flush = 0, misalign_err = 0, mispredict_count = 0, all PHT entries = 01 (weakly not-taken).
REQ-038 Reset asserted mid-REDIRECT drops redirect_valid immediately (asynchronously); ex_ready = 1 after release.

Structure
REQ-039 Package rv32i_branch_pkg holds the FSM state enum, the 2-bit counter typedef, the PHT_INIT constant (01) and the misalignment mask.
REQ-040 The predictor table is a sub-module, rv32i_bimodal_pht: one combinational read port, one synchronous write port, asynchronous reset.

Verification
REQ-041 BEQ at pc 0x100, imm 0x20, taken, predicted not-taken -> redirect_pc 0x120, flush pulse, count 1, PHT[0] 01->10.
REQ-042 BNE at pc 0x200, not taken, predicted not-taken -> no redirect, count unchanged, PHT[0] 01->00.
REQ-043 JALR, rs1 0x1003, imm 0 -> target 0x1002 -> misalign_err pulse, no redirect, no flush.
REQ-044 Mispredict with redirect_ready low for 3 cycles -> redirect_valid held 4 cycles, flush only in first, ex_ready 0 throughout.
REQ-045 Four taken branches at pc 0x40 -> PHT[0] saturates at 11; if_pc 0x40 reads 1 before and after.
REQ-046 rst asserted during REDIRECT -> redirect_valid 0 the same cycle, count 0, all PHT entries 01.

Source files
------------

// File: rtl/rv32i_branch_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rv32i_branch_pkg
// Shared types and constants for EX-stage branch resolution and the bimodal
// predictor table.
// Revision: 1.0
// ----------------------------------------------------------------------------
package rv32i_branch_pkg;

   // Resolution FSM: accepting new resolutions, or holding a fetch redirect.
   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_REDIRECT = 1'b1
   } state_e;

   // Two-bit saturating predictor counter; MSB is the taken prediction.
   typedef logic [1:0] ctr2_t;

   // Weakly not-taken.
   localparam ctr2_t PHT_INIT = 2'b01;

   // Low target bits that must be zero for a legal RV32I (no C) target.
   localparam logic [1:0] MISALIGN_MASK = 2'b11;

   // Saturating up/down step of a two-bit counter.
   function automatic ctr2_t ctr_next(input ctr2_t c, input logic taken);
      ctr2_t r;
      r = c;
      if (taken) begin
         if (c != 2'b11) r = c + 2'b01;
      end else begin
         if (c != 2'b00) r = c - 2'b01;
      end
      return r;
   endfunction

endpackage : rv32i_branch_pkg
`default_nettype wire

// File: rtl/rv32i_bimodal_pht.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rv32i_bimodal_pht
// Bimodal pattern history table: one combinational read port for fetch,
// one synchronous read-modify-write update port for EX, async reset.
// Revision: 1.0
// ----------------------------------------------------------------------------
module rv32i_bimodal_pht
   import rv32i_branch_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic             rd_taken_o,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  logic             wr_taken_i
);

   ctr2_t pht_q [ENTRIES];

   // Counter storage: reset to weakly not-taken, saturating update on write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            pht_q[i] <= PHT_INIT;
         end
      end else if (wr_en_i) begin
         pht_q[wr_idx_i] <= ctr_next(pht_q[wr_idx_i], wr_taken_i);
      end
   end

   // Read sees the stored value, so a same-entry update is not forwarded.
   assign rd_taken_o = pht_q[rd_idx_i][1];

endmodule : rv32i_bimodal_pht
`default_nettype wire

// File: rtl/rv32i_branch_resolve.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rv32i_branch_resolve
// EX-stage control-transfer resolution: computes the real target, detects
// mispredicts and misaligned targets, drives a held fetch redirect with a
// one-cycle flush, counts mispredicts and trains a bimodal predictor.
// Revision: 1.0
// ----------------------------------------------------------------------------
module rv32i_branch_resolve
   import rv32i_branch_pkg::*;
#(
   parameter int PHT_ENTRIES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic        ex_is_branch,
   input  logic        ex_is_jal,
   input  logic        ex_is_jalr,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_imm,
   input  logic [31:0] ex_rs1_data,
   input  logic        branch_taken,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pred_target,
   output logic        ex_ready,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        redirect_ready,
   output logic        flush,
   output logic        misalign_err,
   input  logic [31:0] if_pc,
   output logic        if_pred_taken,
   output logic [31:0] mispredict_count
);

   localparam int IDX_W = $clog2(PHT_ENTRIES);

   state_e      state_q, state_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;
   logic        flush_q, flush_d;
   logic        misalign_q, misalign_d;
   logic [31:0] count_q, count_d;

   logic        w_resolve;
   logic        w_actual_taken;
   logic [31:0] w_target;
   logic [31:0] w_correct_pc;
   logic        w_mispredict;
   logic        w_misaligned;

   // Only the index bits of the PCs feed the predictor.
   logic        w_unused_pc_bits;
   assign w_unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

   assign ex_ready       = (state_q == ST_IDLE);
   assign redirect_valid = (state_q == ST_REDIRECT);
   assign redirect_pc    = redirect_pc_q;
   assign flush          = flush_q;
   assign misalign_err   = misalign_q;
   assign mispredict_count = count_q;

   assign w_resolve = ex_valid & ex_ready & (ex_is_branch | ex_is_jal | ex_is_jalr);

   // Actual outcome, target and mispredict/misalign classification.
   always_comb begin
      w_actual_taken = ex_is_branch ? branch_taken : 1'b1;
      if (ex_is_jalr) begin
         w_target = (ex_rs1_data + ex_imm) & ~32'd1;
      end else begin
         w_target = ex_pc + ex_imm;
      end
      w_correct_pc = w_actual_taken ? w_target : (ex_pc + 32'd4);
      w_mispredict = (ex_pred_taken != w_actual_taken) |
                     (w_actual_taken & (ex_pred_target != w_target));
      w_misaligned = w_actual_taken & ((w_target[1:0] & MISALIGN_MASK) != 2'b00);
   end

   // Next-state and registered-output logic; misalignment beats mispredict.
   always_comb begin
      state_d       = state_q;
      redirect_pc_d = redirect_pc_q;
      flush_d       = 1'b0;
      misalign_d    = 1'b0;
      count_d       = count_q;
      case (state_q)
         ST_IDLE: begin
            if (w_resolve) begin
               if (w_misaligned) begin
                  misalign_d = 1'b1;
               end else if (w_mispredict) begin
                  state_d       = ST_REDIRECT;
                  redirect_pc_d = w_correct_pc;
                  flush_d       = 1'b1;
                  if (count_q != 32'hFFFF_FFFF) count_d = count_q + 32'd1;
               end
            end
         end
         ST_REDIRECT: begin
            if (redirect_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         redirect_pc_q <= 32'd0;
         flush_q       <= 1'b0;
         misalign_q    <= 1'b0;
         count_q       <= 32'd0;
      end else begin
         state_q       <= state_d;
         redirect_pc_q <= redirect_pc_d;
         flush_q       <= flush_d;
         misalign_q    <= misalign_d;
         count_q       <= count_d;
      end
   end

   rv32i_bimodal_pht #(
      .ENTRIES (PHT_ENTRIES),
      .IDX_W   (IDX_W)
   ) u_pht (
      .clk        (clk),
      .rst        (rst),
      .rd_idx_i   (if_pc[IDX_W+1:2]),
      .rd_taken_o (if_pred_taken),
      .wr_en_i    (w_resolve & ex_is_branch),
      .wr_idx_i   (ex_pc[IDX_W+1:2]),
      .wr_taken_i (branch_taken)
   );

endmodule : rv32i_branch_resolve
`default_nettype wire

// File: tb/tb_rv32i_branch_resolve.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rv32i_branch_resolve
// Directed self-checking bench for rv32i_branch_resolve.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_rv32i_branch_resolve;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
   logic [31:0] ex_pc, ex_imm, ex_rs1_data;
   logic        branch_taken, ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic        ex_ready, redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_ready, flush, misalign_err;
   logic [31:0] if_pc;
   logic        if_pred_taken;
   logic [31:0] mispredict_count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   rv32i_branch_resolve #(.PHT_ENTRIES(16)) dut (
      .clk              (clk),
      .rst              (rst),
      .ex_valid         (ex_valid),
      .ex_is_branch     (ex_is_branch),
      .ex_is_jal        (ex_is_jal),
      .ex_is_jalr       (ex_is_jalr),
      .ex_pc            (ex_pc),
      .ex_imm           (ex_imm),
      .ex_rs1_data      (ex_rs1_data),
      .branch_taken     (branch_taken),
      .ex_pred_taken    (ex_pred_taken),
      .ex_pred_target   (ex_pred_target),
      .ex_ready         (ex_ready),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .redirect_ready   (redirect_ready),
      .flush            (flush),
      .misalign_err     (misalign_err),
      .if_pc            (if_pc),
      .if_pred_taken    (if_pred_taken),
      .mispredict_count (mispredict_count)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ex;
      ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
      ex_pc = 0; ex_imm = 0; ex_rs1_data = 0;
      branch_taken = 0; ex_pred_taken = 0; ex_pred_target = 0;
   endtask

   task automatic do_reset;
      clear_ex();
      redirect_ready = 0;
      if_pc = 0;
      rst = 1;
      step();
      rst = 0;
      #1;
   endtask

   task automatic drive_branch(input logic [31:0] pc, input logic [31:0] imm,
                               input logic taken, input logic ptaken,
                               input logic [31:0] ptarget);
      clear_ex();
      ex_valid = 1; ex_is_branch = 1; ex_pc = pc; ex_imm = imm;
      branch_taken = taken; ex_pred_taken = ptaken; ex_pred_target = ptarget;
   endtask

   task automatic test_reset;
      do_reset();
      n_tests++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ex_ready got %b exp 1", ex_ready); end
      n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL reset_redirect_valid got %b exp 0", redirect_valid); end
      n_tests++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_redirect_pc got %h exp 0", redirect_pc); end
      n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %b exp 0", flush); end
      n_tests++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got %b exp 0", misalign_err); end
      n_tests++; if (mispredict_count !== 32'h0) begin n_fail++; $display("FAIL reset_count got %h exp 0", mispredict_count); end
      n_tests++; if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred got %b exp 0", if_pred_taken); end
   endtask

   // BEQ 0x100 +0x20 taken, predicted not-taken.
   task automatic test_beq_mispredict;
      do_reset();
      if_pc = 32'h100;
      drive_branch(32'h100, 32'h20, 1'b1, 1'b0, 32'h0);
      #1;
      n_tests++; if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL beq_pre_update_pred got %b exp 0", if_pred_taken); end
      step();
      clear_ex();
      n_tests++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL beq_redirect_valid got %b exp 1", redirect_valid); end
      n_tests++; if (redirect_pc !== 32'h120) begin n_fail++; $display("FAIL beq_redirect_pc got %h exp 120", redirect_pc); end
      n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL beq_flush got %b exp 1", flush); end
      n_tests++; if (mispredict_count !== 32'd1) begin n_fail++; $display("FAIL beq_count got %0d exp 1", mispredict_count); end
      n_tests++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL beq_ex_ready got %b exp 0", ex_ready); end
      n_tests++; if (if_pred_taken !== 1'b1) begin n_fail++; $display("FAIL beq_pht_10 got %b exp 1", if_pred_taken); end
      redirect_ready = 1;
      step();
      redirect_ready = 0;
      n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL beq_release_valid got %b exp 0", redirect_valid); end
      n_tests++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL beq_release_ready got %b exp 1", ex_ready); end
      n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL beq_flush_drop got %b exp 0", flush); end
   endtask

   // BNE 0x200 not taken, predicted not-taken: PHT 01->00, then a correctly
   // predicted taken branch moves it to 01 (still not-taken prediction).
   task automatic test_bne_correct;
      do_reset();
      if_pc = 32'h200;
      drive_branch(32'h200, 32'h10, 1'b0, 1'b0, 32'h0);
      step();
      clear_ex();
      n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL bne_redirect got %b exp 0", redirect_valid); end
      n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL bne_flush got %b exp 0", flush); end
      n_tests++; if (mispredict_count !== 32'd0) begin n_fail++; $display("FAIL bne_count got %0d exp 0", mispredict_count); end
      n_tests++; if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL bne_pht_00 got %b exp 0", if_pred_taken); end
      drive_branch(32'h200, 32'h10, 1'b1, 1'b1, 32'h210);
      step();
      clear_ex();
      n_tests++; if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL bne_pht_01 got %b exp 0", if_pred_taken); end
      n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL bne_taken_ok_redirect got %b exp 0", redirect_valid); end
   endtask

   // Misaligned JALR and branch targets; aligned JALR; JAL wrong target.
   task automatic test_jumps;
      do_reset();
      if_pc = 32'h0;
      clear_ex();
      ex_valid = 1; ex_is_jalr = 1; ex_pc = 32'h0; ex_rs1_data = 32'h1003; ex_imm = 32'h0;
      step();
      clear_ex();
      n_tests++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL jalr_misalign got %b exp 1", misalign_err); end
      n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL jalr_mis_redirect got %b exp 0", redirect_valid); end
      n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL jalr_mis_flush got %b exp 0", flush); end
      n_tests++; if (mispredict_count !== 32'd0) begin n_fail++; $display("FAIL jalr_mis_count got %0d exp 0", mispredict_count); end
      n_tests++; if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL jalr_no_pht got %b exp 0", if_pred_taken); end
      step();
      n_tests++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL jalr_mis_pulse got %b exp 0", misalign_err); end
      // Aligned JALR: (0x1001+0x10)&~1 = 0x1010, predicted correctly.
      ex_valid = 1; ex_is_jalr = 1; ex_pc = 32'h0; ex_rs1_data = 32'h1001; ex_imm = 32'h10;
      ex_pred_taken = 1; ex_pred_target = 32'h1010;
      step();
      clear_ex();
      n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL jalr_ok_redirect got %b exp 0", redirect_valid); end
      n_tests++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL jalr_ok_misalign got %b exp 0", misalign_err); end
      // Misaligned conditional branch still trains the PHT (01->10).
      drive_branch(32'h0, 32'h22, 1'b1, 1'b0, 32'h0);
      step();
      clear_ex();
      n_tests++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL br_misalign got %b exp 1", misalign_err); end
      n_tests++; if (if_pred_taken !== 1'b1) begin n_fail++; $display("FAIL br_misalign_pht got %b exp 1", if_pred_taken); end
      n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL br_misalign_redirect got %b exp 0", redirect_valid); end
      // JAL 0x300+0x40 = 0x340 but predicted target 0x344.
      ex_valid = 1; ex_is_jal = 1; ex_pc = 32'h300; ex_imm = 32'h40;
      ex_pred_taken = 1; ex_pred_target = 32'h344;
      step();
      clear_ex();
      n_tests++; if (redirect_pc !== 32'h340) begin n_fail++; $display("FAIL jal_redirect_pc got %h exp 340", redirect_pc); end
      n_tests++; if (mispredict_count !== 32'd1) begin n_fail++; $display("FAIL jal_count got %0d exp 1", mispredict_count); end
      redirect_ready = 1;
      step();
      redirect_ready = 0;
   endtask

   // Redirect back-pressure: held 4 cycles, flush only first; EX ignored.
   task automatic test_redirect_stall;
      do_reset();
      if_pc = 32'h100;
      drive_branch(32'h100, 32'h20, 1'b1, 1'b0, 32'h0);
      step();
      // Mispredicting not-taken branch on the same entry, must be ignored.
      drive_branch(32'h100, 32'h20, 1'b0, 1'b1, 32'h120);
      for (int k = 0; k < 4; k++) begin
         n_tests++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d] got %b exp 1", k, redirect_valid); end
         n_tests++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ex_ready[%0d] got %b exp 0", k, ex_ready); end
         n_tests++; if (flush !== (k == 0)) begin n_fail++; $display("FAIL stall_flush[%0d] got %b exp %b", k, flush, (k == 0)); end
         n_tests++; if (redirect_pc !== 32'h120) begin n_fail++; $display("FAIL stall_pc[%0d] got %h exp 120", k, redirect_pc); end
         if (k == 3) begin
            redirect_ready = 1;
            ex_valid = 0;
         end
         step();
      end
      redirect_ready = 0;
      clear_ex();
      n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL stall_done_valid got %b exp 0", redirect_valid); end
      n_tests++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL stall_done_ready got %b exp 1", ex_ready); end
      n_tests++; if (mispredict_count !== 32'd1) begin n_fail++; $display("FAIL stall_count got %0d exp 1", mispredict_count); end
      n_tests++; if (if_pred_taken !== 1'b1) begin n_fail++; $display("FAIL stall_pht_frozen got %b exp 1", if_pred_taken); end
   endtask

   // Back-to-back correct taken branches at 0x40 saturate at 11.
   task automatic test_back_to_back;
      logic [3:0] exp_after;
      do_reset();
      if_pc = 32'h40;
      exp_after = 4'b1111;
      n_tests++; if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL sat_initial got %b exp 0", if_pred_taken); end
      for (int k = 0; k < 4; k++) begin
         drive_branch(32'h40, 32'h8, 1'b1, 1'b1, 32'h48);
         step();
         n_tests++; if (if_pred_taken !== exp_after[k]) begin n_fail++; $display("FAIL sat_taken[%0d] got %b exp %b", k, if_pred_taken, exp_after[k]); end
      end
      // 11 -> 10 (still taken) -> 01 (not taken).
      drive_branch(32'h40, 32'h8, 1'b0, 1'b0, 32'h0);
      step();
      n_tests++; if (if_pred_taken !== 1'b1) begin n_fail++; $display("FAIL sat_dec1 got %b exp 1", if_pred_taken); end
      step();
      clear_ex();
      n_tests++; if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL sat_dec2 got %b exp 0", if_pred_taken); end
      n_tests++; if (mispredict_count !== 32'd0) begin n_fail++; $display("FAIL sat_count got %0d exp 0", mispredict_count); end
      n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL sat_redirect got %b exp 0", redirect_valid); end
   endtask

   // Async reset in the middle of REDIRECT.
   task automatic test_reset_in_redirect;
      do_reset();
      if_pc = 32'h100;
      drive_branch(32'h100, 32'h20, 1'b1, 1'b0, 32'h0);
      step();
      clear_ex();
      n_tests++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_valid got %b exp 1", redirect_valid); end
      #2;
      rst = 1;
      #1;
      n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b exp 0", redirect_valid); end
      n_tests++; if (mispredict_count !== 32'd0) begin n_fail++; $display("FAIL rstmid_count got %0d exp 0", mispredict_count); end
      n_tests++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL rstmid_pc got %h exp 0", redirect_pc); end
      n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL rstmid_flush got %b exp 0", flush); end
      n_tests++; if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL rstmid_pht got %b exp 0", if_pred_taken); end
      step();
      rst = 0;
      #1;
      n_tests++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %b exp 1", ex_ready); end
   endtask

   initial begin
      rst = 1;
      redirect_ready = 0;
      if_pc = 0;
      clear_ex();
      test_reset();
      test_beq_mispredict();
      test_bne_correct();
      test_jumps();
      test_redirect_stall();
      test_back_to_back();
      test_reset_in_redirect();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_rv32i_branch_resolve
`default_nettype wire
